gf_serial_mult: RTL

- Parametrised, digit-serial multiplier for the GF operations library; successor to the combinational multiplier comparison top.
- Computes one of three products of two DATA_WIDTH-bit operands over several clock cycles:
  - integer product
  - carry-less GF(2)[x] product
  - field product reduced modulo a fixed irreducible polynomial
- Valid/ready handshakes on input and output let it sit in a pipelined GF datapath.

---
 rtl/gf_pkg.sv | 18 +
 rtl/gf_reduce.sv | 28 ++
 rtl/gf_serial_mult.sv | 125 ++++++++++++
 3 files changed

// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared mode encodings, state type and default polynomial for GF blocks
package gf_pkg;

  localparam logic [1:0] GF_MODE_INT   = 2'b00;
  localparam logic [1:0] GF_MODE_CLMUL = 2'b01;
  localparam logic [1:0] GF_MODE_RED   = 2'b10;

  // x^4 + x + 1 with the leading term implicit
  localparam logic [3:0] GF_POLY4 = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RED  = 2'd2,
    ST_DONE = 2'd3
  } gf_state_e;

endpackage

// File: rtl/gf_reduce.sv
// rtl/gf_reduce.sv - combinational reduction of a 2m-bit GF(2)[x] product modulo POLY
module gf_reduce
  import gf_pkg::*;
#(
  parameter int                    DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] POLY       = GF_POLY4
) (
  input  logic [2*DATA_WIDTH-1:0] i_prod,
  output logic [DATA_WIDTH-1:0]   o_rem
);

  localparam logic [2*DATA_WIDTH-1:0] FULL_POLY = {{(DATA_WIDTH-1){1'b0}}, 1'b1, POLY};

  logic [2*DATA_WIDTH-1:0] w_tmp;

  // Clear the top set bit first so each XOR can only disturb lower bits.
  always_comb begin
    w_tmp = i_prod;
    for (int i = 2*DATA_WIDTH-2; i >= DATA_WIDTH; i--) begin
      if (w_tmp[i]) begin
        w_tmp = w_tmp ^ (FULL_POLY << (i - DATA_WIDTH));
      end
    end
  end

  assign o_rem = w_tmp[DATA_WIDTH-1:0];

endmodule

// File: rtl/gf_serial_mult.sv
// rtl/gf_serial_mult.sv - digit-serial integer / carry-less / field multiplier with valid-ready
module gf_serial_mult
  import gf_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    DIGIT_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] POLY        = GF_POLY4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              gf_option,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int N     = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_digit
      $error("gf_serial_mult: DIGIT_WIDTH must divide DATA_WIDTH");
    end
  endgenerate

  gf_state_e             r_state;
  gf_state_e             w_next;
  logic [PW-1:0]         r_mcand;
  logic [PW-1:0]         r_acc;
  logic [PW-1:0]         r_out;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [1:0]            r_mode;
  logic [CNT_W-1:0]      r_cnt;
  logic [PW-1:0]         w_sum_int;
  logic [PW-1:0]         w_sum_xor;
  logic [PW-1:0]         w_acc_next;
  logic [DATA_WIDTH-1:0] w_rem;
  logic                  w_last;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out       = r_out;
  assign w_last    = (r_cnt == LAST);

  // r_mcand holds a << (counter*DIGIT_WIDTH); r_mplier's low bits are the current digit of b.
  always_comb begin
    w_sum_int = r_acc;
    w_sum_xor = r_acc;
    for (int j = 0; j < DIGIT_WIDTH; j++) begin
      if (r_mplier[j]) begin
        w_sum_int = w_sum_int + (r_mcand << j);
        w_sum_xor = w_sum_xor ^ (r_mcand << j);
      end
    end
    w_acc_next = (r_mode == GF_MODE_INT) ? w_sum_int : w_sum_xor;
  end

  gf_reduce #(
    .DATA_WIDTH(DATA_WIDTH),
    .POLY      (POLY)
  ) u_reduce (
    .i_prod(r_acc),
    .o_rem (w_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_MUL;
      ST_MUL:  if (w_last) w_next = (r_mode == GF_MODE_RED) ? ST_RED : ST_DONE;
      ST_RED:  w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_mode   <= GF_MODE_INT;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{DATA_WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_mode   <= gf_option;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << DIGIT_WIDTH;
          r_mplier <= r_mplier >> DIGIT_WIDTH;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last && (r_mode != GF_MODE_RED)) begin
            r_out <= w_acc_next;
          end
        end
        ST_RED: r_out <= {{DATA_WIDTH{1'b0}}, w_rem};
        default: ;
      endcase
    end
  end

endmodule
